uart_tx_fifo: RTL and testbench

//  Byte FIFO + launch controller sitting directly upstream of the uart transmitter.

---
 rtl/uart_tx_fifo_if.sv | 30 +++
 rtl/uart_tx_fifo.sv | 126 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side and transmitter-side signals of the uart_tx_fifo block.
// master: the host/uart side that pushes bytes and reports frame completion.
// slave:  the FIFO/launch controller itself.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       wr_data;
  logic             wr_en;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [7:0]       TxData;
  logic             TxEnable;
  logic             TxDone;
  logic             busy;
  logic             tx_err;

  modport master (
    output wr_data, wr_en, TxDone,
    input  full, empty, count, overflow, TxData, TxEnable, busy, tx_err
  );

  modport slave (
    input  wr_data, wr_en, TxDone,
    output full, empty, count, overflow, TxData, TxEnable, busy, tx_err
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter. Launches one byte at a time with a
// single-cycle TxEnable, then waits for a TxDone rising edge before the next.
// A watchdog abandons the wait after TIMEOUT cycles and sets a sticky error.
//
// state | meaning
// IDLE  | no byte in flight; launches as soon as the FIFO is not empty
// SEND  | TxEnable pulse cycle; watchdog cleared
// WAIT  | byte in flight; waiting for TxDone rise or watchdog expiry
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 200000
) (
  input  logic          tck,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       tx_data_q;
  logic             tx_enable_q;
  logic             overflow_q;
  logic             tx_err_q;
  logic [WD_W-1:0]  wdog;
  logic             done_q;

  logic full, empty, push, done_rise;
  logic launch, wdog_clr, wdog_inc, err_set;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = bus.wr_en & ~full;
  assign done_rise = bus.TxDone & ~done_q;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.TxData   = tx_data_q;
  assign bus.TxEnable = tx_enable_q;
  assign bus.busy     = (state != IDLE);
  assign bus.tx_err   = tx_err_q;

  // Launch controller state register.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control strobes; TxDone rises outside WAIT are ignored.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    wdog_clr  = 1'b0;
    wdog_inc  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          launch    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        wdog_clr  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          state_nxt = IDLE;
        end else begin
          wdog_inc = 1'b1;
          if (wdog == WD_W'(TIMEOUT - 1)) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge tck) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // Pointers, occupancy, launch register, watchdog and status flags.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      tx_data_q   <= 8'h00;
      tx_enable_q <= 1'b0;
      overflow_q  <= 1'b0;
      tx_err_q    <= 1'b0;
      wdog        <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= bus.TxDone;
      overflow_q  <= bus.wr_en & full;
      tx_enable_q <= launch;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (launch) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        tx_data_q <= mem[rd_ptr];
      end
      case ({push, launch})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (wdog_clr)      wdog <= '0;
      else if (wdog_inc) wdog <= wdog + WD_W'(1);
      if (err_set) tx_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a per-cycle vector table for the basic
// launch/complete flow, then hand-written multi-cycle sequences.
module tb_uart_tx_fifo;
  logic tck = 1'b0;
  logic reset = 1'b0;
  always #5 tck = ~tck;

  uart_tx_fifo_if #(.DEPTH(16)) bus ();
  uart_tx_fifo_if #(.DEPTH(16)) bus_w ();

  uart_tx_fifo #(.DEPTH(16), .TIMEOUT(200000)) dut (
    .tck(tck), .reset(reset), .bus(bus)
  );
  uart_tx_fifo #(.DEPTH(16), .TIMEOUT(50)) dut_w (
    .tck(tck), .reset(reset), .bus(bus_w)
  );

  int total = 0;
  int bad   = 0;
  int ten_cnt = 0;
  bit bad_byte = 1'b0;

  // Counts launch pulses on the main instance and flags any dropped byte being sent.
  always @(negedge tck) begin
    if (bus.TxEnable === 1'b1) begin
      ten_cnt++;
      if (bus.TxData == 8'hEE || bus.TxData == 8'hEF) bad_byte = 1'b1;
    end
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       done;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       txen;
    logic       busy;
    logic       ovf;
    logic [7:0] txdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic we, logic [7:0] wd, logic dn, logic [4:0] c,
                              logic e, logic f, logic te, logic b, logic o, logic [7:0] td);
    vec_t v;
    v.wr_en = we; v.wr_data = wd; v.done = dn; v.count = c; v.empty = e;
    v.full = f; v.txen = te; v.busy = b; v.ovf = o; v.txdata = td;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic wait_txen(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.TxEnable !== 1'b1 && n < budget);
    if (bus.TxEnable !== 1'b1) n = -1;
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.TxDone = 1'b0;
    bus_w.wr_en = 1'b0; bus_w.wr_data = 8'h00; bus_w.TxDone = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    bit stable;

    // Table: inputs applied, one edge, outputs sampled
    vecs[0]  = mk(1, 8'hA5, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 8'hA5);
    vecs[2]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 8'hA5);
    vecs[3]  = mk(1, 8'h11, 0, 1, 0, 0, 0, 1, 0, 8'hA5);
    vecs[4]  = mk(1, 8'h22, 0, 2, 0, 0, 0, 1, 0, 8'hA5);
    vecs[5]  = mk(0, 8'h00, 1, 2, 0, 0, 0, 0, 0, 8'hA5);
    vecs[6]  = mk(0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 8'h11);
    vecs[7]  = mk(0, 8'h00, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    vecs[8]  = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h11);
    vecs[9]  = mk(0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 8'h22);
    vecs[10] = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 8'h22);
    vecs[11] = mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h22);
    vecs[12] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h22);

    do_reset();
    chk("reset_state", {bus.count, bus.empty, bus.full, bus.TxEnable, bus.busy, bus.overflow, bus.TxData},
        {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    chk("reset_tx_err", {bus.tx_err, bus_w.tx_err}, 2'b00);

    for (int i = 0; i < 13; i++) begin
      bus.wr_en = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      bus.TxDone = vecs[i].done;
      tick();
      chk($sformatf("vec%0d", i),
          {bus.count, bus.empty, bus.full, bus.TxEnable, bus.busy, bus.overflow, bus.TxData},
          {vecs[i].count, vecs[i].empty, vecs[i].full, vecs[i].txen, vecs[i].busy, vecs[i].ovf, vecs[i].txdata});
    end

    // Single byte, completion 1000 cycles after launch
    do_reset();
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    tick();
    chk("t1_launch", {bus.TxEnable, bus.busy, bus.TxData}, {1'b1, 1'b1, 8'hA5});
    chk("t1_count0", bus.count, 0);
    tick();
    chk("t1_pulse_end", bus.TxEnable, 0);
    repeat (997) tick();
    chk("t1_still_busy", {bus.busy, bus.TxData}, {1'b1, 8'hA5});
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    chk("t1_done", {bus.busy, bus.empty}, 2'b01);
    tick();
    chk("t1_no_relaunch", bus.TxEnable, 0);

    // Three bytes back-to-back with a TxDone stub
    do_reset();
    base = ten_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i + 1);
      tick();
    end
    bus.wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus.TxData !== 8'(k + 1) || bus.TxEnable !== 1'b0) stable = 1'b0;
      end
      chk($sformatf("t2_stable%0d", k), stable, 1);
      bus.TxDone = 1'b1;
      tick();
      bus.TxDone = 1'b0;
      if (k < 2) begin
        wait_txen(10, n);
        chk($sformatf("t2_b2b_edges%0d", k), n + 1, 2);
        chk($sformatf("t2_data%0d", k), bus.TxData, 8'(k + 2));
      end
    end
    repeat (5) tick();
    chk("t2_pulses", ten_cnt - base, 3);
    chk("t2_idle_empty", {bus.busy, bus.empty}, 2'b01);

    // Fill to full with TxDone stalled, then overflow
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
      tick();
      if (i == 1) chk("t3_push_pop", {bus.count, bus.TxEnable, bus.TxData}, {5'd1, 1'b1, 8'h40});
    end
    chk("t3_full", {bus.count, bus.full, bus.overflow}, {5'd16, 1'b1, 1'b0});
    bus.wr_data = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    chk("t3_overflow", {bus.count, bus.overflow}, {5'd16, 1'b1});
    tick();
    chk("t3_ovf_pulse_end", {bus.count, bus.overflow}, {5'd16, 1'b0});
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'hEF;
    tick();
    bus.wr_en = 1'b0;
    chk("t3_pop_no_rescue", {bus.TxEnable, bus.TxData, bus.count, bus.overflow},
        {1'b1, 8'h41, 5'd15, 1'b1});
    for (int i = 0; i < 15; i++) begin
      tick();
      bus.TxDone = 1'b1;
      tick();
      bus.TxDone = 1'b0;
      wait_txen(10, n);
      chk($sformatf("t3_drain%0d", i), {n[7:0], bus.TxData}, {8'd1, 8'(8'h42 + i)});
    end
    tick();
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    repeat (4) tick();
    chk("t3_drained", {bus.empty, bus.busy, bad_byte}, 3'b100);

    // Watchdog on the short-timeout instance
    do_reset();
    bus_w.wr_en = 1'b1; bus_w.wr_data = 8'hC1;
    tick();
    bus_w.wr_data = 8'hC2;
    tick();
    bus_w.wr_en = 1'b0;
    chk("t4_launch1", {bus_w.TxEnable, bus_w.TxData, bus_w.count}, {1'b1, 8'hC1, 5'd1});
    tick();
    repeat (49) tick();
    chk("t4_before_fire", {bus_w.tx_err, bus_w.busy}, 2'b01);
    tick();
    chk("t4_fire", {bus_w.tx_err, bus_w.busy}, 2'b10);
    tick();
    chk("t4_next_launch", {bus_w.TxEnable, bus_w.TxData, bus_w.count, bus_w.tx_err},
        {1'b1, 8'hC2, 5'd0, 1'b1});
    tick();
    bus_w.TxDone = 1'b1;
    tick();
    bus_w.TxDone = 1'b0;
    chk("t4_sticky", {bus_w.tx_err, bus_w.busy, bus_w.empty}, 3'b101);
    do_reset();
    chk("t4_cleared", bus_w.tx_err, 0);

    // Asynchronous reset while waiting with four bytes queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h60 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    chk("t5_pre", {bus.count, bus.busy}, {5'd4, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async", {bus.count, bus.empty, bus.TxEnable, bus.busy}, {5'd0, 1'b1, 1'b0, 1'b0});
    @(negedge tck);
    reset = 1'b1;
    tick();
    base = ten_cnt;
    bus.TxDone = 1'b1;
    repeat (5) tick();
    bus.TxDone = 1'b0;
    tick();
    chk("t5_late_done", {ten_cnt - base, 32'(bus.busy)}, {32'd0, 32'd0});

    // TxDone high through IDLE/SEND is not a completion
    do_reset();
    bus.TxDone = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    tick();
    bus.wr_en = 1'b0;
    tick();
    chk("t6_launch", {bus.TxEnable, bus.TxData}, {1'b1, 8'h77});
    tick();
    repeat (5) tick();
    chk("t6_level_ignored", bus.busy, 1);
    bus.TxDone = 1'b0;
    tick();
    chk("t6_low", bus.busy, 1);
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    chk("t6_wait_rise", {bus.busy, bus.empty}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
